// File: rtl/sign_window_sched_if.sv
// rtl/sign_window_sched_if.sv - control, bitstream and result signals of the sign window scheduler
// Ports (slave = scheduler side):
//   start, win_len, abort   window request / abort from the controller
//   in_bits                 one unary bit per channel from the SNG/RNG bank
//   bs_clr, bs_en           clear pulse and enable back to the generators
//   busy                    scheduler not idle
//   sign_vld, sign_rdy,
//   sign_out                captured signs with valid/ready handshake
interface sign_window_sched_if #(
    parameter int NCH  = 4,
    parameter int LENW = 8
);
    logic            start;
    logic [LENW-1:0] win_len;
    logic            abort;
    logic [NCH-1:0]  in_bits;
    logic            bs_clr;
    logic            bs_en;
    logic            busy;
    logic            sign_vld;
    logic            sign_rdy;
    logic [NCH-1:0]  sign_out;

    modport master (
        output start, win_len, abort, in_bits, sign_rdy,
        input  bs_clr, bs_en, busy, sign_vld, sign_out
    );

    modport slave (
        input  start, win_len, abort, in_bits, sign_rdy,
        output bs_clr, bs_en, busy, sign_vld, sign_out
    );
endinterface

// File: rtl/sign_window_sched.sv
// rtl/sign_window_sched.sv - windowed sign evaluation of NCH bipolar unary bitstreams
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   bus      sign_window_sched_if.slave (request, bitstream, result signals)
// One saturating DEP-bit up/down counter per channel runs for win_len cycles
// after a one-cycle generator clear; sign = ~counter MSB is captured for all
// channels at once and held until the downstream handshake.
module sign_window_sched #(
    parameter int NCH  = 4,
    parameter int DEP  = 3,
    parameter int LENW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sign_window_sched_if.slave bus
);
    localparam logic [DEP-1:0]  CNT_MID = {1'b1, {(DEP-1){1'b0}}};
    localparam logic [DEP-1:0]  CNT_MAX = '1;
    localparam logic [LENW-1:0] REM_ONE = LENW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_HOLD
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [LENW-1:0] rem_q;
    logic [DEP-1:0]  cnt_q [NCH];
    logic [DEP-1:0]  cnt_d [NCH];
    logic [NCH-1:0]  sign_q;
    logic [NCH-1:0]  sign_d;
    logic            abort_hit;
    logic            start_acc;

    // Abort only has an effect outside IDLE, but it still outranks a start.
    assign abort_hit = bus.abort && (state_q != S_IDLE);
    assign start_acc = (state_q == S_IDLE) && bus.start && !bus.abort
                       && (bus.win_len != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus outputs, all decoded from the registered state.
    always_comb begin
        state_d      = state_q;
        bus.bs_clr   = 1'b0;
        bus.bs_en    = 1'b0;
        bus.busy     = 1'b1;
        bus.sign_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (start_acc) state_d = S_CLR;
            end
            S_CLR: begin
                bus.bs_clr = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                bus.bs_en = 1'b1;
                if (rem_q == REM_ONE) state_d = S_HOLD;
            end
            S_HOLD: begin
                bus.sign_vld = 1'b1;
                if (bus.sign_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    // Saturating counter update; sign_d reflects the value after this cycle's bit.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.in_bits[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!bus.in_bits[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            sign_d[i] = ~cnt_d[i][DEP-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            sign_q <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= CNT_MID;
        end else if (abort_hit) begin
            rem_q <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= CNT_MID;
        end else begin
            if (start_acc) rem_q <= bus.win_len;
            if (state_q == S_CLR) begin
                for (int i = 0; i < NCH; i++) cnt_q[i] <= CNT_MID;
            end
            if (state_q == S_RUN) begin
                rem_q <= rem_q - 1'b1;
                for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
                if (rem_q == REM_ONE) sign_q <= sign_d;
            end
        end
    end

    assign bus.sign_out = sign_q;
endmodule

// File: tb/tb_sign_window_sched.sv
// tb/tb_sign_window_sched.sv - directed self-checking bench for sign_window_sched
module tb_sign_window_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] pat [256];
    logic       vld_seen;

    sign_window_sched_if #(.NCH(4), .LENW(8)) bus ();

    sign_window_sched #(.NCH(4), .DEP(3), .LENW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill(input logic [3:0] v);
        for (int i = 0; i < 256; i++) pat[i] = v;
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the HOLD entry edge.
    task automatic run_window(input string tag, input int len, input logic [3:0] exp_sign);
        int en_cnt;
        en_cnt = 0;
        bus.start   = 1'b1;
        bus.win_len = 8'(len);
        step();
        bus.start = 1'b0;
        check({tag, "_clr"}, 32'(bus.bs_clr), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        for (int e = 1; e <= len + 1; e++) begin
            step();
            if (bus.bs_en) begin
                bus.in_bits = pat[en_cnt];
                en_cnt++;
            end
            if (e == len) check({tag, "_vld_early"}, 32'(bus.sign_vld), 32'd0);
        end
        check({tag, "_en_cycles"}, 32'(en_cnt), 32'(len));
        check({tag, "_vld"}, 32'(bus.sign_vld), 32'd1);
        check({tag, "_sign"}, 32'(bus.sign_out), 32'(exp_sign));
    endtask

    task automatic handshake(input string tag);
        bus.sign_rdy = 1'b1;
        step();
        bus.sign_rdy = 1'b0;
        bus.start    = 1'b0;
        check({tag, "_hs_vld"}, 32'(bus.sign_vld), 32'd0);
        check({tag, "_hs_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.win_len  = '0;
        bus.abort    = 1'b0;
        bus.in_bits  = '0;
        bus.sign_rdy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_clr", 32'(bus.bs_clr), 32'd0);
        check("rst_en", 32'(bus.bs_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_vld", 32'(bus.sign_vld), 32'd0);
        check("rst_sign", 32'(bus.sign_out), 32'd0);

        // All ones: counters climb 4->7 and saturate.
        fill(4'b1111);
        run_window("all1", 8, 4'b0000);
        handshake("all1");

        // All zeros, then backpressure with start pulses during HOLD.
        fill(4'b0000);
        run_window("all0", 8, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            bus.start   = (i % 2 == 0);
            bus.win_len = 8'd8;
            step();
            check("bp_vld", 32'(bus.sign_vld), 32'd1);
            check("bp_sign", 32'(bus.sign_out), 32'hf);
            check("bp_busy", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b1;
        handshake("bp");

        // Mixed per-channel patterns (ch3..ch0 per step).
        pat[0] = 4'b1100; pat[1] = 4'b0101; pat[2] = 4'b0100; pat[3] = 4'b0111;
        pat[4] = 4'b0100; pat[5] = 4'b0101; pat[6] = 4'b0110; pat[7] = 4'b0101;
        run_window("mix", 8, 4'b1010);
        handshake("mix");

        // Zero-length request is ignored.
        bus.start   = 1'b1;
        bus.win_len = 8'd0;
        step();
        bus.start = 1'b0;
        check("len0_busy", 32'(bus.busy), 32'd0);
        check("len0_clr", 32'(bus.bs_clr), 32'd0);
        step();
        check("len0_busy2", 32'(bus.busy), 32'd0);
        check("len0_sign", 32'(bus.sign_out), 32'ha);

        // Single-cycle window: ch1,ch0 go to 5, ch3,ch2 go to 3.
        fill(4'b0011);
        run_window("len1", 1, 4'b1100);
        handshake("len1");

        // Abort during the third RUN cycle.
        fill(4'b1111);
        bus.start   = 1'b1;
        bus.win_len = 8'd8;
        step();
        bus.start   = 1'b0;
        bus.in_bits = 4'b1111;
        step();
        step();
        step();
        check("abort_pre_en", 32'(bus.bs_en), 32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_en", 32'(bus.bs_en), 32'd0);
        check("abort_vld", 32'(bus.sign_vld), 32'd0);
        check("abort_sign", 32'(bus.sign_out), 32'hc);
        vld_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.sign_vld) vld_seen = 1'b1;
        end
        check("abort_no_vld", 32'(vld_seen), 32'd0);

        // Asynchronous reset in the middle of RUN.
        bus.start   = 1'b1;
        bus.win_len = 8'd8;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("rstmid_pre_en", 32'(bus.bs_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_en", 32'(bus.bs_en), 32'd0);
        check("rstmid_clr", 32'(bus.bs_clr), 32'd0);
        check("rstmid_vld", 32'(bus.sign_vld), 32'd0);
        check("rstmid_sign", 32'(bus.sign_out), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Normal window after the reset.
        fill(4'b0000);
        run_window("post", 8, 4'b1111);
        handshake("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
